// File: rtl/decoder38_seq.sv
// Sequenced 3-to-8 decoder. Codes arrive over valid/ready into a small FIFO
// and are replayed as one-hot words, each held for HOLD cycles while en is
// high. Dropping en aborts the word being driven but leaves the queue intact.
module decoder38_seq #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic [2:0]               in,
    output logic                     in_ready,
    output logic [7:0]               out,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [AW:0]   FULL      = (AW + 1)'(DEPTH);

    typedef enum logic {IDLE, DRIVE} state_t;

    state_t          state, state_nxt;
    logic [2:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic [7:0]      out_nxt;
    logic            out_valid_nxt;
    logic            push, pop;
    logic [2:0]      head;

    // Ready comes only from the registered occupancy, so a full FIFO refuses
    // a push even when the FSM pops in the same cycle.
    assign in_ready = (count != FULL);
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];
    assign busy     = out_valid | (count != '0);

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output FSM next-state: load a word from IDLE, hold it, then either
    // chain straight into the next queued code or fall back to IDLE.
    always_comb begin
        state_nxt     = state;
        hold_nxt      = hold_cnt;
        out_nxt       = out;
        out_valid_nxt = out_valid;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                out_nxt       = 8'h00;
                out_valid_nxt = 1'b0;
                if (en && count != '0) begin
                    pop           = 1'b1;
                    out_nxt       = 8'b1 << head;
                    out_valid_nxt = 1'b1;
                    hold_nxt      = HOLD_LAST;
                    state_nxt     = DRIVE;
                end
            end
            DRIVE: begin
                if (!en) begin
                    out_nxt       = 8'h00;
                    out_valid_nxt = 1'b0;
                    hold_nxt      = '0;
                    state_nxt     = IDLE;
                end else if (hold_cnt != '0) begin
                    hold_nxt = hold_cnt - 1'b1;
                end else if (count != '0) begin
                    pop      = 1'b1;
                    out_nxt  = 8'b1 << head;
                    hold_nxt = HOLD_LAST;
                end else begin
                    out_nxt       = 8'h00;
                    out_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                out_nxt       = 8'h00;
                out_valid_nxt = 1'b0;
                hold_nxt      = '0;
                state_nxt     = IDLE;
            end
        endcase
    end

    // Output FSM registers; out is registered so it never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            out       <= 8'h00;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            out       <= out_nxt;
            out_valid <= out_valid_nxt;
        end
    end

endmodule
